// File: rtl/iic_share_arb.sv
// rtl/iic_share_arb.sv - two-requester arbiter in front of one shared I2C driver (optional macro: IIC_ARB_RR_EN)
module iic_share_arb #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  device_id0,
  input  logic [7:0]  device_id1,
  input  logic        iic_trig0,
  input  logic        iic_trig1,
  input  logic        w_r0,
  input  logic        w_r1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  data_in0,
  input  logic [7:0]  data_in1,
  output logic        busy0,
  output logic        busy1,
  output logic [7:0]  data_out0,
  output logic [7:0]  data_out1,
  output logic        byte_over0,
  output logic        byte_over1,
  output logic [7:0]  m_device_id,
  output logic        m_w_r,
  output logic [15:0] m_addr,
  output logic [7:0]  m_data_in,
  output logic        m_iic_trig,
  input  logic        m_busy,
  input  logic        m_byte_over,
  input  logic [7:0]  m_data_out,
  output logic        arb_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_pend;
  logic            r_grant;
  logic            r_last_grant;
  logic            r_abort;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_nxt;
  logic            w_grant_sel;
  logic            w_waiting;
  logic            w_timeout;

  logic [7:0]      r_dev  [2];
  logic            r_wr   [2];
  logic [15:0]     r_addr [2];
  logic [7:0]      r_din  [2];
  logic [1:0]      w_trig;
  logic [7:0]      w_dev  [2];
  logic            w_wr   [2];
  logic [15:0]     w_addr [2];
  logic [7:0]      w_din  [2];

  assign w_trig    = {iic_trig1, iic_trig0};
  assign w_dev[0]  = device_id0;
  assign w_dev[1]  = device_id1;
  assign w_wr[0]   = w_r0;
  assign w_wr[1]   = w_r1;
  assign w_addr[0] = addr0;
  assign w_addr[1] = addr1;
  assign w_din[0]  = data_in0;
  assign w_din[1]  = data_in1;

  assign busy0 = r_pend[0];
  assign busy1 = r_pend[1];

`ifdef IIC_ARB_RR_EN
  assign w_grant_sel = (&r_pend) ? ~r_last_grant : ~r_pend[0];
`else
  assign w_grant_sel = ~r_pend[0];
`endif

  // Saturating increment; the timer counts from the issue cycle so an abort
  // lands exactly TIMEOUT_CYC cycles after m_iic_trig.
  assign w_timer_nxt = (r_timer == TMO) ? r_timer : r_timer + TW'(1);
  assign w_timeout   = (w_timer_nxt == TMO);
  assign w_waiting   = (r_state == S_WAIT_START) || (r_state == S_WAIT_DONE);

  // Next-state decode and combinational strobes
  always_comb begin
    w_state_nxt = r_state;
    m_iic_trig  = 1'b0;
    arb_err     = 1'b0;
    byte_over0  = m_byte_over && w_waiting && (r_grant == 1'b0);
    byte_over1  = m_byte_over && w_waiting && (r_grant == 1'b1);
    case (r_state)
      S_IDLE:       if (|r_pend) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        m_iic_trig  = 1'b1;
        w_state_nxt = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (m_busy)         w_state_nxt = S_WAIT_DONE;
        else if (w_timeout) w_state_nxt = S_DONE;
      end
      S_WAIT_DONE:  if (!m_busy) w_state_nxt = S_DONE;
      S_DONE: begin
        arb_err     = r_abort;
        w_state_nxt = S_IDLE;
      end
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Start-timeout timer and abort flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
      r_abort <= 1'b0;
    end else begin
      case (r_state)
        S_ISSUE:      r_timer <= w_timer_nxt;
        S_WAIT_START: begin
          r_timer <= w_timer_nxt;
          if (!m_busy && w_timeout) r_abort <= 1'b1;
        end
        S_WAIT_DONE:  r_timer <= r_timer;
        S_DONE:       r_timer <= '0;
        default: begin
          r_timer <= '0;
          r_abort <= 1'b0;
        end
      endcase
    end
  end

  // Per-slot request capture; a slot already pending ignores new triggers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      for (int i = 0; i < 2; i++) begin
        r_dev[i]  <= '0;
        r_wr[i]   <= 1'b0;
        r_addr[i] <= '0;
        r_din[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_trig[i] && !r_pend[i]) begin
          r_pend[i] <= 1'b1;
          r_dev[i]  <= w_dev[i];
          r_wr[i]   <= w_wr[i];
          r_addr[i] <= w_addr[i];
          r_din[i]  <= w_din[i];
        end else if ((r_state == S_DONE) && (r_grant == 1'(i))) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  // Grant selection and driver field load; fields hold until the next grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      m_device_id  <= '0;
      m_w_r        <= 1'b0;
      m_addr       <= '0;
      m_data_in    <= '0;
    end else if ((r_state == S_IDLE) && (|r_pend)) begin
      r_grant     <= w_grant_sel;
      m_device_id <= r_dev[w_grant_sel];
      m_w_r       <= r_wr[w_grant_sel];
      m_addr      <= r_addr[w_grant_sel];
      m_data_in   <= r_din[w_grant_sel];
    end else if (r_state == S_DONE) begin
      r_last_grant <= r_grant;
    end
  end

  // Read data capture for the granted requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out0 <= '0;
      data_out1 <= '0;
    end else if (m_byte_over) begin
      if (r_grant == 1'b0) data_out0 <= m_data_out;
      else                 data_out1 <= m_data_out;
    end
  end

endmodule

// File: tb/tb_iic_share_arb.sv
// tb/tb_iic_share_arb.sv - self-checking bench for iic_share_arb
module tb_iic_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  device_id0, device_id1;
  logic        iic_trig0, iic_trig1;
  logic        w_r0, w_r1;
  logic [15:0] addr0, addr1;
  logic [7:0]  data_in0, data_in1;
  logic        busy0, busy1;
  logic [7:0]  data_out0, data_out1;
  logic        byte_over0, byte_over1;
  logic [7:0]  m_device_id;
  logic        m_w_r;
  logic [15:0] m_addr;
  logic [7:0]  m_data_in;
  logic        m_iic_trig;
  logic        m_busy, m_byte_over;
  logic [7:0]  m_data_out;
  logic        arb_err;

  always #5 clk = ~clk;

  iic_share_arb #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .device_id0(device_id0), .device_id1(device_id1),
    .iic_trig0(iic_trig0), .iic_trig1(iic_trig1),
    .w_r0(w_r0), .w_r1(w_r1),
    .addr0(addr0), .addr1(addr1),
    .data_in0(data_in0), .data_in1(data_in1),
    .busy0(busy0), .busy1(busy1),
    .data_out0(data_out0), .data_out1(data_out1),
    .byte_over0(byte_over0), .byte_over1(byte_over1),
    .m_device_id(m_device_id), .m_w_r(m_w_r), .m_addr(m_addr), .m_data_in(m_data_in),
    .m_iic_trig(m_iic_trig),
    .m_busy(m_busy), .m_byte_over(m_byte_over), .m_data_out(m_data_out),
    .arb_err(arb_err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int trig_cnt = 0;
  int err_cnt  = 0;
  int busy1_seen = 0;

  always @(negedge clk) begin
    if (m_iic_trig) trig_cnt++;
    if (arb_err)    err_cnt++;
    if (busy1)      busy1_seen++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_trig(input string nm);
    int n = 0;
    while (!m_iic_trig && n < 20) begin
      tick();
      n++;
    end
    chk(nm, m_iic_trig, 1'b1);
  endtask

  // Drive a driver transaction starting from the ISSUE cycle; returns in IDLE.
  task automatic serve(input int blen);
    tick();
    m_busy = 1'b1;
    repeat (blen) tick();
    m_busy = 1'b0;
    tick();
    tick();
  endtask

  typedef struct {
    logic       trig0, trig1, mbusy, mbo;
    logic [7:0] mdout;
    logic       e_busy0, e_busy1, e_mtrig, e_bo0, e_bo1;
    logic [7:0] e_dout0, e_dout1;
    logic       e_err;
  } vec_t;

  vec_t vt[9];
  int   t0;
  logic exp_first;

  initial begin
    // slot-1 read, one row per clock
    vt[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b0};
    vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b0};
    vt[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b0};

    rst_n = 1'b0;
    iic_trig0 = 1'b0; iic_trig1 = 1'b0;
    device_id0 = 8'h50; device_id1 = 8'h51;
    w_r0 = 1'b1; w_r1 = 1'b0;
    addr0 = 16'h1234; addr1 = 16'hBEEF;
    data_in0 = 8'h5A; data_in1 = 8'h00;
    m_busy = 1'b0; m_byte_over = 1'b0; m_data_out = 8'h00;
    repeat (3) tick();

    chk("rst_busy0", busy0, 1'b0);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_mtrig", m_iic_trig, 1'b0);
    chk("rst_err", arb_err, 1'b0);
    chk("rst_dout0", data_out0, 8'h00);
    chk("rst_maddr", m_addr, 16'h0000);
    rst_n = 1'b1;
    tick();

    // read on slot 1
    for (int i = 0; i < 9; i++) begin
      iic_trig0   = vt[i].trig0;
      iic_trig1   = vt[i].trig1;
      m_busy      = vt[i].mbusy;
      m_byte_over = vt[i].mbo;
      m_data_out  = vt[i].mdout;
      #3;
      chk($sformatf("rd%0d_busy0", i), busy0, vt[i].e_busy0);
      chk($sformatf("rd%0d_busy1", i), busy1, vt[i].e_busy1);
      chk($sformatf("rd%0d_mtrig", i), m_iic_trig, vt[i].e_mtrig);
      chk($sformatf("rd%0d_bo0", i), byte_over0, vt[i].e_bo0);
      chk($sformatf("rd%0d_bo1", i), byte_over1, vt[i].e_bo1);
      chk($sformatf("rd%0d_dout0", i), data_out0, vt[i].e_dout0);
      chk($sformatf("rd%0d_dout1", i), data_out1, vt[i].e_dout1);
      chk($sformatf("rd%0d_err", i), arb_err, vt[i].e_err);
      if (i == 2) begin
        chk("rd_maddr", m_addr, 16'hBEEF);
        chk("rd_mwr", m_w_r, 1'b0);
      end
      tick();
    end

    // single write on slot 0, m_busy high for 20 cycles
    t0 = trig_cnt;
    busy1_seen = 0;
    iic_trig0 = 1'b1;
    tick();
    iic_trig0 = 1'b0;
    wait_trig("wr_trig");
    chk("wr_maddr", m_addr, 16'h1234);
    chk("wr_mdin", m_data_in, 8'h5A);
    chk("wr_mwr", m_w_r, 1'b1);
    chk("wr_mdev", m_device_id, 8'h50);
    tick();
    m_busy = 1'b1;
    repeat (19) tick();
    m_busy = 1'b0;
    tick();
    chk("wr_busy0_done", busy0, 1'b1);
    tick();
    chk("wr_busy0_idle", busy0, 1'b0);
    chk("wr_trig_cnt", trig_cnt - t0, 1);
    chk("wr_busy1_seen", busy1_seen, 0);
    chk("wr_maddr_hold", m_addr, 16'h1234);

    // simultaneous triggers; last completed grant was slot 0
`ifdef IIC_ARB_RR_EN
    exp_first = 1'b1;
`else
    exp_first = 1'b0;
`endif
    addr0 = 16'h0A0A; addr1 = 16'h1B1B;
    t0 = trig_cnt;
    iic_trig0 = 1'b1; iic_trig1 = 1'b1;
    tick();
    iic_trig0 = 1'b0; iic_trig1 = 1'b0;
    #1;
    chk("sim_busy0", busy0, 1'b1);
    chk("sim_busy1", busy1, 1'b1);
    wait_trig("sim_trig_a");
    chk("sim_first_addr", m_addr, exp_first ? 16'h1B1B : 16'h0A0A);
    serve(3);
    chk("sim_turn_idle", m_iic_trig, 1'b0);
    tick();
    chk("sim_turn_issue", m_iic_trig, 1'b1);
    chk("sim_second_addr", m_addr, exp_first ? 16'h0A0A : 16'h1B1B);
    serve(3);
    repeat (3) tick();
    chk("sim_trig_cnt", trig_cnt - t0, 2);
    chk("sim_idle_busy", {busy1, busy0}, 2'b00);

    // start timeout: m_busy never rises
    t0 = err_cnt;
    iic_trig0 = 1'b1;
    tick();
    iic_trig0 = 1'b0;
    wait_trig("to_trig");
    begin
      int n = 0;
      while (!arb_err && n < 40) begin
        tick();
        n++;
      end
      chk("to_latency", n, 16);
    end
    chk("to_busy0_done", busy0, 1'b1);
    tick();
    chk("to_err_low", arb_err, 1'b0);
    chk("to_busy0_idle", busy0, 1'b0);
    tick();
    chk("to_no_reissue", m_iic_trig, 1'b0);
    chk("to_err_cnt", err_cnt - t0, 1);

    // reset in WAIT_DONE with both slots pending
    iic_trig0 = 1'b1; iic_trig1 = 1'b1;
    tick();
    iic_trig0 = 1'b0; iic_trig1 = 1'b0;
    wait_trig("rs_trig");
    tick();
    m_busy = 1'b1;
    tick();
    tick();
    chk("rs_pre_busy", {busy1, busy0}, 2'b11);
    m_byte_over = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rs_busy", {busy1, busy0}, 2'b00);
    chk("rs_bo", {byte_over1, byte_over0}, 2'b00);
    chk("rs_mtrig", m_iic_trig, 1'b0);
    chk("rs_dout1", data_out1, 8'h00);
    chk("rs_mfields", {m_device_id, m_w_r, m_addr, m_data_in}, 33'h0);
    tick();
    m_byte_over = 1'b0;
    m_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    t0 = trig_cnt;
    repeat (10) tick();
    chk("rs_no_trig", trig_cnt - t0, 0);
    chk("rs_idle_busy", {busy1, busy0}, 2'b00);
    iic_trig1 = 1'b1;
    tick();
    iic_trig1 = 1'b0;
    wait_trig("rs_new_trig");
    chk("rs_new_addr", m_addr, 16'h1B1B);
    serve(2);
    chk("rs_new_cnt", trig_cnt - t0, 1);

    // slot 0 held triggering through the whole transaction including DONE
    t0 = trig_cnt;
    iic_trig0 = 1'b1;
    tick();
    wait_trig("rt_trig");
    tick();
    m_busy = 1'b1;
    repeat (3) tick();
    m_busy = 1'b0;
    tick();
    tick();
    iic_trig0 = 1'b0;
    #1;
    chk("rt_busy0_idle", busy0, 1'b0);
    repeat (5) tick();
    chk("rt_trig_cnt", trig_cnt - t0, 1);
    chk("rt_busy0_end", busy0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/iic_share_arb.md
IIC_SHARE_ARB -- requirements
Module: iic_share_arb

Interface
REQ-001 Parameter: TIMEOUT_CYC, 1000, max clk cycles from master trigger to master busy rise before the transaction is aborted.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 device_id0 / device_id1  input  8  requester N I2C device address.
REQ-005 iic_trig0 / iic_trig1  input  1  requester N single-cycle transaction request pulse.
REQ-006 w_r0 / w_r1  input  1  requester N direction; 1 = write, 0 = read.
REQ-007 addr0 / addr1  input  16  requester N register address.
REQ-008 data_in0 / data_in1  input  8  requester N write data.
REQ-009 busy0 / busy1  output  1  requester N request pending or in progress.
REQ-010 data_out0 / data_out1  output  8  requester N read data.
REQ-011 byte_over0 / byte_over1  output  1  requester N byte-complete strobe.
REQ-012 m_device_id, m_w_r, m_addr[15:0], m_data_in[7:0]  output  8/1/16/8  fields to the shared I2C driver.
REQ-013 m_iic_trig  output  1  single-cycle trigger to the shared I2C driver.
REQ-014 m_busy, m_byte_over, m_data_out[7:0]  input  1/1/8  status and read data from the shared I2C driver.
REQ-015 arb_err  output  1  one-cycle pulse on timeout abort.

Function
REQ-016 Capture: iic_trigN=1 while pendN=0 SHALL latch device_idN, w_rN, addrN and data_inN into slot N and set pendN; iic_trigN while pendN=1 is ignored.
REQ-017 busyN SHALL equal registered pendN, rising the cycle after the accepted trigger and staying high until the slot's transaction completes.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT_START, WAIT_DONE, DONE.
REQ-019 IDLE: any pend set -> ISSUE; the grant is chosen and the granted slot fields are loaded into the m_* field registers on this transition.
REQ-020 ISSUE: m_iic_trig=1 for exactly one cycle -> WAIT_START; the timer clears.
REQ-021 WAIT_START: m_busy=1 -> WAIT_DONE; timer reaches TIMEOUT_CYC -> DONE with the abort flag set.
REQ-022 WAIT_DONE: m_busy=0 -> DONE.
REQ-023 DONE: clear pend[grant], record last_grant, pulse arb_err if aborted, -> IDLE; a trigger on the granted slot in this cycle is ignored (pend still 1).
REQ-024 The m_* field outputs SHALL be held stable from ISSUE until the next grant.
REQ-025 byte_overN SHALL equal m_byte_over gated by grant==N and state in WAIT_START or WAIT_DONE, combinational; the other requester sees 0.
REQ-026 data_outN SHALL be registered from m_data_out when m_byte_over=1 with grant==N, and hold otherwise.
REQ-027 Minimum turnaround: a second pending slot is issued no earlier than 2 cycles after DONE (DONE -> IDLE -> ISSUE).
REQ-028 The timer width SHALL be $clog2(TIMEOUT_CYC+1); the timer saturates and does not wrap.

Reset
REQ-029 rst_n low SHALL force, asynchronously: state IDLE; pend0, pend1, last_grant=1, timer, abort flag, busyN, byte_overN, m_iic_trig and arb_err all 0; data_outN, m_device_id, m_w_r, m_addr and m_data_in 0.
REQ-030 A reset mid-transaction SHALL drop all pending requests; no m_iic_trig is issued until a new trigger is accepted after reset release.

Configuration
REQ-031 Macro IIC_ARB_RR_EN defined: when both slots are pending in IDLE, the grant goes to the slot other than last_grant (round-robin).
REQ-032 Macro IIC_ARB_RR_EN undefined: when both slots are pending, slot 0 always wins (fixed priority); last_grant is still maintained.

Verification
REQ-033 Single write: iic_trig0 with addr0=16'h1234 and data_in0=8'h5A; model m_busy high for 20 cycles -> one m_iic_trig, m_addr=16'h1234, busy0 high until 1 cycle after m_busy falls, busy1=0 throughout.
REQ-034 Simultaneous triggers, RR on, last_grant=0 -> slot 1 is served first, then slot 0; exactly two m_iic_trig pulses; RR off -> slot 0 is served first.
REQ-035 Read: iic_trig1 with w_r1=0; model returns m_data_out=8'hC3 with m_byte_over -> data_out1=8'hC3, byte_over1 pulses, byte_over0 stays 0 and data_out0 is unchanged.
REQ-036 Timeout: TIMEOUT_CYC=16 and m_busy never rises -> arb_err pulses once 16 cycles after ISSUE, busy0 falls and the FSM returns to IDLE.
REQ-037 Reset mid-WAIT_DONE, with both slots pending -> all outputs zero immediately; no m_iic_trig after reset release until a new trigger.
REQ-038 Re-trigger of slot 0 while pend0=1, including in the DONE cycle -> ignored; only one transaction is issued.
